demux_1to8_16bit: RTL and testbench

Registered 1-to-8 demultiplexer. Routes one WIDTH-bit data word to one of eight output channels selected by a 3-bit select. The non-selected channels are driven to zero (Nand2Tetris DMux8Way semantics, widened to a bus).
Sits as a generic fan-out/steering stage between a single producer and eight consumers. Registered outputs give clean timing.

---
 rtl/demux_1to8_16bit_pkg.sv | 9 +
 rtl/demux_1to8_16bit_onehot_decoder.sv | 18 +
 rtl/demux_1to8_16bit.sv | 80 ++++++++
 tb/tb_demux_1to8_16bit.sv | 114 +++++++++++
 4 files changed

// File: rtl/demux_1to8_16bit_pkg.sv
// Shared constants for the registered 1-to-8 demultiplexer and its select decoder.
// Channel count and select width are fixed; only the data width is a parameter.
package demux_1to8_16bit_pkg;

    localparam int DATA_W = 16;
    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

endpackage : demux_1to8_16bit_pkg

// File: rtl/demux_1to8_16bit_onehot_decoder.sv
// 3-to-8 one-hot decoder with enable.
// The top uses the same decode for channel load gating and for the out_valid strobe.
module onehot_decoder_3to8
    import demux_1to8_16bit_pkg::*;
(
    input  logic [SEL_W-1:0]  sel,
    input  logic              en,
    output logic [NUM_CH-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule : onehot_decoder_3to8

// File: rtl/demux_1to8_16bit.sv
// Registered 1-to-8 demultiplexer: steers one word to the selected channel.
// All other channels are driven to zero, and out_valid is a one-hot strobe.
module demux_1to8_16bit
    import demux_1to8_16bit_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in,
    input  logic [SEL_W-1:0]  sel,
    input  logic              in_valid,
    output logic [WIDTH-1:0]  out1,
    output logic [WIDTH-1:0]  out2,
    output logic [WIDTH-1:0]  out3,
    output logic [WIDTH-1:0]  out4,
    output logic [WIDTH-1:0]  out5,
    output logic [WIDTH-1:0]  out6,
    output logic [WIDTH-1:0]  out7,
    output logic [WIDTH-1:0]  out8,
    output logic [NUM_CH-1:0] out_valid
);

    logic [NUM_CH-1:0]             load;
    logic [NUM_CH-1:0]             valid_d;
    logic [NUM_CH-1:0]             valid_q;
    logic [NUM_CH-1:0][WIDTH-1:0]  ch_data;

    onehot_decoder_3to8 u_decoder (
        .sel    (sel),
        .en     (in_valid),
        .onehot (load)
    );

    always_comb begin
        valid_d = load;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Unselected channels reload zero every cycle, so nothing holds a stale word.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [WIDTH-1:0] ch_d;
        logic [WIDTH-1:0] ch_q;

        always_comb begin
            ch_d = '0;
            if (load[k]) begin
                ch_d = in;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                ch_q <= '0;
            end else begin
                ch_q <= ch_d;
            end
        end

        assign ch_data[k] = ch_q;
    end

    assign out1      = ch_data[0];
    assign out2      = ch_data[1];
    assign out3      = ch_data[2];
    assign out4      = ch_data[3];
    assign out5      = ch_data[4];
    assign out6      = ch_data[5];
    assign out7      = ch_data[6];
    assign out8      = ch_data[7];
    assign out_valid = valid_q;

endmodule : demux_1to8_16bit

// File: tb/tb_demux_1to8_16bit.sv
// Directed self-checking bench for demux_1to8_16bit.
// Each vector is driven before a rising edge and checked 1 ns after it.
module tb_demux_1to8_16bit;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic [2:0]  sel;
    logic        in_valid;
    logic [15:0] out1, out2, out3, out4, out5, out6, out7, out8;
    logic [7:0]  out_valid;

    int errorCount;
    int checkCount;

    demux_1to8_16bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .sel       (sel),
        .in_valid  (in_valid),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out5      (out5),
        .out6      (out6),
        .out7      (out7),
        .out8      (out8),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // expCh is the 0-based channel expected to carry expWord; -1 means all channels zero.
    task automatic applyStimulus(input string tag, input logic rstN, input logic [15:0] word,
                                 input logic [2:0] s, input logic v,
                                 input logic [7:0] expValid, input int expCh,
                                 input logic [15:0] expWord);
        logic [127:0] expData;
        logic [127:0] obsData;
        rst_n    = rstN;
        in       = word;
        sel      = s;
        in_valid = v;
        @(posedge clk);
        #1;
        expData = '0;
        if (expCh >= 0) begin
            expData[expCh*16 +: 16] = expWord;
        end
        obsData = {out8, out7, out6, out5, out4, out3, out2, out1};
        checkOutput({tag, "/data"}, obsData, expData);
        checkOutput({tag, "/valid"}, {120'd0, out_valid}, {120'd0, expValid});
    endtask

    initial begin
        errorCount = 0;
        checkCount = 0;
        rst_n      = 1'b0;
        in         = '0;
        sel        = '0;
        in_valid   = 1'b0;

        applyStimulus("reset0", 1'b0, 16'hFFFF, 3'd3, 1'b1, 8'h00, -1, 16'h0000);
        applyStimulus("reset1", 1'b0, 16'hFFFF, 3'd3, 1'b1, 8'h00, -1, 16'h0000);

        applyStimulus("sweep0", 1'b1, 16'hFFFF, 3'd0, 1'b1, 8'h01, 0, 16'hFFFF);
        applyStimulus("sweep1", 1'b1, 16'hFFFF, 3'd1, 1'b1, 8'h02, 1, 16'hFFFF);
        applyStimulus("sweep2", 1'b1, 16'hFFFF, 3'd2, 1'b1, 8'h04, 2, 16'hFFFF);
        applyStimulus("sweep3", 1'b1, 16'hFFFF, 3'd3, 1'b1, 8'h08, 3, 16'hFFFF);
        applyStimulus("sweep4", 1'b1, 16'hFFFF, 3'd4, 1'b1, 8'h10, 4, 16'hFFFF);
        applyStimulus("sweep5", 1'b1, 16'hFFFF, 3'd5, 1'b1, 8'h20, 5, 16'hFFFF);
        applyStimulus("sweep6", 1'b1, 16'hFFFF, 3'd6, 1'b1, 8'h40, 6, 16'hFFFF);
        applyStimulus("sweep7", 1'b1, 16'hFFFF, 3'd7, 1'b1, 8'h80, 7, 16'hFFFF);

        applyStimulus("dist6", 1'b1, 16'hA5C3, 3'd5, 1'b1, 8'h20, 5, 16'hA5C3);
        applyStimulus("dist3", 1'b1, 16'h1234, 3'd2, 1'b1, 8'h04, 2, 16'h1234);

        applyStimulus("same3a", 1'b1, 16'hBEEF, 3'd2, 1'b1, 8'h04, 2, 16'hBEEF);
        applyStimulus("same3b", 1'b1, 16'h0F0F, 3'd2, 1'b1, 8'h04, 2, 16'h0F0F);

        applyStimulus("load4", 1'b1, 16'h5A5A, 3'd3, 1'b1, 8'h08, 3, 16'h5A5A);
        applyStimulus("idle",  1'b1, 16'h5A5A, 3'd3, 1'b0, 8'h00, -1, 16'h0000);

        applyStimulus("mid0",   1'b1, 16'hFFFF, 3'd0, 1'b1, 8'h01, 0, 16'hFFFF);
        applyStimulus("mid1",   1'b1, 16'hFFFF, 3'd1, 1'b1, 8'h02, 1, 16'hFFFF);
        applyStimulus("mid2",   1'b1, 16'hFFFF, 3'd2, 1'b1, 8'h04, 2, 16'hFFFF);
        applyStimulus("mid3",   1'b1, 16'hFFFF, 3'd3, 1'b1, 8'h08, 3, 16'hFFFF);
        applyStimulus("midrst", 1'b0, 16'hFFFF, 3'd4, 1'b1, 8'h00, -1, 16'h0000);
        applyStimulus("mid4",   1'b1, 16'hFFFF, 3'd4, 1'b1, 8'h10, 4, 16'hFFFF);
        applyStimulus("mid5",   1'b1, 16'hFFFF, 3'd5, 1'b1, 8'h20, 5, 16'hFFFF);
        applyStimulus("mid6",   1'b1, 16'hFFFF, 3'd6, 1'b1, 8'h40, 6, 16'hFFFF);
        applyStimulus("mid7",   1'b1, 16'hFFFF, 3'd7, 1'b1, 8'h80, 7, 16'hFFFF);

        applyStimulus("zero8", 1'b1, 16'h0000, 3'd7, 1'b1, 8'h80, -1, 16'h0000);
        applyStimulus("odd1",  1'b1, 16'h8001, 3'd0, 1'b1, 8'h01, 0, 16'h8001);
        applyStimulus("idle2", 1'b1, 16'h8001, 3'd0, 1'b0, 8'h00, -1, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule : tb_demux_1to8_16bit
